// File: rtl/song_sequencer.sv
// Song sequencer: steps through a fixed note table and presents each entry to the
// tone generator for its timed length, followed by a silent gap, until the end marker.
module song_sequencer #(
   parameter int unsigned TICKS_PER_UNIT = 6_250_000,
   parameter int unsigned GAP_TICKS      = 1_000_000,
   parameter int unsigned MAX_NOTES      = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       start,
   input  logic       loop,
   input  logic [2:0] song,
   output logic [2:0] octave,
   output logic [2:0] note,
   output logic [3:0] length,
   output logic       tone_en,
   output logic [6:0] led,
   output logic [4:0] note_idx,
   output logic       busy,
   output logic       done,
   output logic [2:0] dbg_state
);

   localparam int CNT_W = 32;
   localparam int IDX_W = $clog2(MAX_NOTES + 1);
   localparam logic [CNT_W-1:0] GAP_LAST = (GAP_TICKS > 0) ? CNT_W'(GAP_TICKS - 1) : '0;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_PLAY = 3'd2,
      S_GAP  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       song_q, song_d;
   logic [2:0]       octave_q, octave_d;
   logic [2:0]       note_q, note_d;
   logic [3:0]       len_q, len_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [9:0]       entry;

   // Entry format {octave, note, length}; length 0 marks the end of a song.
   function automatic logic [9:0] table_entry(input logic [2:0] s, input logic [IDX_W-1:0] i);
      logic [9:0] e;
      e = '0;
      case (s)
         3'd0: if (i < IDX_W'(7))  e = {3'd4, i[2:0] + 3'd1, 4'd4};
         3'd1: e = {3'd5, i[2:0], 4'd1};
         3'd2: if (i < IDX_W'(7))  e = {3'd5, 3'd7 - i[2:0], 4'd2};
         3'd3: if (i < IDX_W'(16)) e = {3'd4, (i[0] ? 3'd0 : 3'd1), 4'd1};
         3'd4: if (i < IDX_W'(8))  e = {3'd3, i[2:0], 4'd8};
         3'd5: if (i < IDX_W'(4))  e = {3'd6, 3'd5, 4'd3};
         3'd6: if (i < IDX_W'(24)) e = {3'd2 + {1'b0, i[1:0]}, 3'd3, 4'd2};
         default: e = '0;
      endcase
      return e;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         song_q   <= '0;
         octave_q <= '0;
         note_q   <= '0;
         len_q    <= '0;
         idx_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         song_q   <= song_d;
         octave_q <= octave_d;
         note_q   <= note_d;
         len_q    <= len_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      song_d   = song_q;
      octave_d = octave_q;
      note_d   = note_q;
      len_d    = len_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      entry    = table_entry(song_q, idx_q);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               song_d  = song;
               idx_d   = '0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (entry[3:0] == 4'd0 || idx_q == IDX_W'(MAX_NOTES)) begin
               state_d = S_DONE;
            end else begin
               octave_d = entry[9:7];
               note_d   = entry[6:4];
               len_d    = entry[3:0];
               cnt_d    = CNT_W'(entry[3:0]) * CNT_W'(TICKS_PER_UNIT) - CNT_W'(1);
               state_d  = S_PLAY;
            end
         end
         S_PLAY: begin
            if (cnt_q == '0) begin
               if (GAP_TICKS > 0) begin
                  cnt_d   = GAP_LAST;
                  state_d = S_GAP;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = S_LOAD;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_GAP: begin
            if (cnt_q == '0) begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = S_LOAD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_DONE: begin
            if (loop) begin
               idx_d   = '0;
               state_d = S_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Dropping the mode enable abandons the song from any state.
      if (!en) state_d = S_IDLE;
   end

   // Outputs decode straight from the state register so reset silences them at once.
   always_comb begin
      octave   = '0;
      note     = '0;
      length   = '0;
      tone_en  = 1'b0;
      led      = '0;
      note_idx = '0;
      busy     = 1'b0;
      done     = 1'b0;
      if (state_q != S_IDLE) begin
         busy     = 1'b1;
         note_idx = 5'(idx_q);
      end
      if (state_q == S_PLAY || state_q == S_GAP) begin
         octave = octave_q;
         note   = note_q;
         length = len_q;
      end
      if (state_q == S_PLAY && note_q != 3'd0) begin
         tone_en = 1'b1;
         led     = 7'd1 << (note_q - 3'd1);
      end
      if (state_q == S_DONE) done = 1'b1;
   end

   assign dbg_state = state_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: a gapped and a gapless build run side by side against a
// schedule model that expands each song into its expected per-cycle output trace.
module tb_song_sequencer;

   localparam int TPU = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en, start, loop;
   logic [2:0] song;

   logic [2:0] oct_a, note_a, dbg_a, oct_b, note_b, dbg_b;
   logic [3:0] len_a, len_b;
   logic [6:0] led_a, led_b;
   logic [4:0] idx_a, idx_b;
   logic       tone_a, busy_a, done_a, tone_b, busy_b, done_b;

   logic [24:0] act [2];
   logic [24:0] cur [2];
   logic [2:0]  lat [2];
   logic [24:0] exp_q0[$];
   logic [24:0] exp_q1[$];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   always #5 clk = ~clk;

   song_sequencer #(.TICKS_PER_UNIT(TPU), .GAP_TICKS(2), .MAX_NOTES(32)) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .start(start), .loop(loop), .song(song),
      .octave(oct_a), .note(note_a), .length(len_a), .tone_en(tone_a), .led(led_a),
      .note_idx(idx_a), .busy(busy_a), .done(done_a), .dbg_state(dbg_a));

   song_sequencer #(.TICKS_PER_UNIT(TPU), .GAP_TICKS(0), .MAX_NOTES(32)) u_dut_nogap (
      .clk(clk), .rst_n(rst_n), .en(en), .start(start), .loop(loop), .song(song),
      .octave(oct_b), .note(note_b), .length(len_b), .tone_en(tone_b), .led(led_b),
      .note_idx(idx_b), .busy(busy_b), .done(done_b), .dbg_state(dbg_b));

   assign act[0] = {busy_a, done_a, tone_a, led_a, oct_a, note_a, len_a, idx_a};
   assign act[1] = {busy_b, done_b, tone_b, led_b, oct_b, note_b, len_b, idx_b};

   function automatic logic [24:0] pack(input logic b, input logic d, input logic t,
                                        input logic [2:0] o, input logic [2:0] n,
                                        input logic [3:0] l, input logic [4:0] i);
      logic [6:0] ld;
      ld = t ? 7'(1 << (int'(n) - 1)) : 7'd0;
      return {b, d, t, ld, o, n, l, i};
   endfunction

   // Songs the bench exercises: 0 = scale, 1 = 32 entries with no end marker, 7 = empty.
   function automatic logic [9:0] song_entry(input logic [2:0] s, input int i);
      if (s == 3'd0) return (i < 7) ? {3'd4, 3'(i + 1), 4'd4} : 10'd0;
      if (s == 3'd1) return {3'd5, 3'(i % 8), 4'd1};
      return 10'd0;
   endfunction

   task automatic push(input int k, input logic [24:0] v);
      if (k == 0) exp_q0.push_back(v);
      else        exp_q1.push_back(v);
   endtask

   task automatic build(input int k, input logic [2:0] s);
      int gap;
      gap = (k == 0) ? 2 : 0;
      for (int i = 0; i <= 32; i++) begin
         logic [9:0] e;
         e = (i == 32) ? 10'd0 : song_entry(s, i);
         push(k, pack(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 4'd0, 5'(i)));
         if (e[3:0] == 4'd0) begin
            push(k, pack(1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 4'd0, 5'(i)));
            break;
         end
         repeat (int'(e[3:0]) * TPU)
            push(k, pack(1'b1, 1'b0, e[6:4] != 3'd0, e[9:7], e[6:4], e[3:0], 5'(i)));
         repeat (gap)
            push(k, pack(1'b1, 1'b0, 1'b0, e[9:7], e[6:4], e[3:0], 5'(i)));
      end
   endtask

   task automatic advance(input int k);
      int sz;
      sz = (k == 0) ? exp_q0.size() : exp_q1.size();
      if (!en) begin
         if (k == 0) exp_q0.delete(); else exp_q1.delete();
         cur[k] = '0;
         return;
      end
      if (sz == 0) begin
         if (cur[k][23] && loop) begin
            build(k, lat[k]);
         end else if (!cur[k][24] && start) begin
            lat[k] = song;
            build(k, song);
         end else begin
            cur[k] = '0;
            return;
         end
      end
      cur[k] = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
   endtask

   task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, a, e);
   endtask

   // One cycle: compare at the falling edge, drive inputs, step the model.
   task automatic cycle(input logic e, input logic s, input logic l, input logic [2:0] sg);
      chk("trace_gap2", 32'(act[0]), 32'(cur[0]));
      chk("trace_gap0", 32'(act[1]), 32'(cur[1]));
      en = e; start = s; loop = l; song = sg;
      advance(0);
      advance(1);
      @(negedge clk);
      cyc++;
   endtask

   task automatic run(input int n, input logic e, input logic s, input logic l,
                      input logic [2:0] sg);
      repeat (n) cycle(e, s, l, sg);
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; start = 1'b0; loop = 1'b0; song = 3'd0;
      cur[0] = '0; cur[1] = '0; lat[0] = '0; lat[1] = '0;
      repeat (2) @(negedge clk);
      chk("reset_busy", 32'(busy_a), 0);
      chk("reset_done", 32'(done_a), 0);
      chk("reset_tone", 32'(tone_a), 0);
      chk("reset_idx",  32'(idx_a), 0);
      rst_n = 1'b1;

      // Song 0, with start and a new song select applied mid-song.
      run(2, 1, 0, 0, 0);
      cycle(1, 1, 0, 0);
      run(1, 1, 0, 0, 0);
      chk("first_tone", 32'(tone_a), 1);
      chk("first_note", 32'(note_a), 1);
      chk("first_oct",  32'(oct_a), 4);
      chk("first_led",  32'(led_a), 32'b0000001);
      run(15, 1, 0, 0, 0);
      chk("note1_last_play", 32'(tone_a), 1);
      run(1, 1, 0, 0, 0);
      chk("note1_gap_tone", 32'(tone_a), 0);
      chk("note1_gap_hold", 32'(note_a), 1);
      chk("nogap_load_tone", 32'(tone_b), 0);
      chk("nogap_load_idx",  32'(idx_b), 1);
      run(1, 1, 0, 0, 0);
      chk("nogap_note2", 32'(note_b), 2);
      run(1, 1, 0, 0, 0);
      chk("load2_idx", 32'(idx_a), 1);
      run(1, 1, 0, 0, 0);
      chk("note2_note", 32'(note_a), 2);
      chk("note2_led",  32'(led_a), 32'b0000010);
      run(90, 1, 1, 0, 5);
      run(24, 1, 0, 0, 0);
      chk("song0_done", 32'(done_a), 1);
      chk("song0_done_busy", 32'(busy_a), 1);
      run(1, 1, 0, 0, 0);
      chk("song0_idle_busy", 32'(busy_a), 0);
      chk("song0_idle_done", 32'(done_a), 0);

      // Empty song.
      cycle(1, 1, 0, 7);
      chk("empty_load_done", 32'(done_a), 0);
      run(1, 1, 0, 0, 0);
      chk("empty_done", 32'(done_a), 1);
      run(1, 1, 0, 0, 0);
      chk("empty_idle", 32'(busy_a), 0);

      // Abort during the third note, then replay.
      cycle(1, 1, 0, 0);
      run(45, 1, 0, 0, 0);
      chk("abort_note3", 32'(note_a), 3);
      cycle(0, 0, 0, 0);
      chk("abort_busy", 32'(busy_a), 0);
      chk("abort_tone", 32'(tone_a), 0);
      chk("abort_led",  32'(led_a), 0);
      run(5, 1, 0, 0, 0);
      cycle(1, 1, 0, 0);
      run(1, 1, 0, 0, 0);
      chk("replay_note", 32'(note_a), 1);
      chk("replay_idx",  32'(idx_a), 0);
      run(3, 0, 0, 0, 0);

      // Looping song 0.
      cycle(1, 1, 1, 0);
      run(134, 1, 0, 1, 0);
      chk("loop_done", 32'(done_a), 1);
      chk("loop_busy", 32'(busy_a), 1);
      run(1, 1, 0, 1, 0);
      chk("loop_idx0", 32'(idx_a), 0);
      chk("loop_load_busy", 32'(busy_a), 1);
      run(1, 1, 0, 1, 0);
      chk("loop_replay", 32'(note_a), 1);
      run(3, 0, 0, 0, 0);

      // Song without end marker; entry 8 is a rest.
      cycle(1, 1, 0, 1);
      run(57, 1, 0, 0, 0);
      chk("rest_tone", 32'(tone_a), 0);
      chk("rest_busy", 32'(busy_a), 1);
      chk("rest_idx",  32'(idx_a), 8);
      run(168, 1, 0, 0, 0);
      chk("max_done", 32'(done_a), 1);
      run(3, 1, 0, 0, 0);

      // Asynchronous reset in the middle of a note.
      cycle(1, 1, 0, 0);
      run(3, 1, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("areset_tone", 32'(tone_a), 0);
      chk("areset_led",  32'(led_a), 0);
      chk("areset_busy", 32'(busy_a), 0);
      chk("areset_idx",  32'(idx_a), 0);
      en = 1'b0; start = 1'b0;
      cur[0] = '0; cur[1] = '0; lat[0] = '0; lat[1] = '0;
      exp_q0.delete(); exp_q1.delete();
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         logic       r_en, r_start, r_loop;
         logic [2:0] r_song;
         logic [2:0] pick [3];
         pick[0] = 3'd0; pick[1] = 3'd1; pick[2] = 3'd7;
         r_en    = ($urandom_range(0, 63) != 0);
         r_start = ($urandom_range(0, 7) == 0);
         r_loop  = ($urandom_range(0, 3) == 0);
         if (!cur[0][24] || !cur[1][24]) r_song = pick[$urandom_range(0, 2)];
         else                            r_song = 3'($urandom_range(0, 7));
         cycle(r_en, r_start, r_loop, r_song);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
